seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 12, operand and result-half width (minimum 4).
REQ-002 SHALL have parameter OPW, default 3, opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL have port opcode  input  OPW  operation select, sampled with start.
REQ-007 SHALL have port op1  input  WIDTH  first operand, sampled with start.
REQ-008 SHALL have port op2  input  WIDTH  second operand, sampled with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result_lo  output  WIDTH  low result half.
REQ-012 SHALL have port result_hi  output  WIDTH  high half (products only; else 0).
REQ-013 SHALL have port flags  output  4  {err, gt, eq, carry}.

Function
REQ-014 SHALL decode 000 NOP, 001 ADD, 010 SUB, 011 UMUL, 100 SMUL, 101 CMP, 110 AND, 111 OR.
REQ-015 SHALL implement FSM IDLE -> EXEC (single-step ops) or MUL (multiply ops) -> DONE -> IDLE.
REQ-016 SHALL accept start=1 in IDLE, latching opcode/op1/op2; subsequent input changes have no effect.
REQ-017 SHALL ignore start while busy=1 (no queueing, no error).
REQ-018 SHALL assert done in cycle N+2 for NOP/ADD/SUB/CMP/AND/OR, start accepted at edge N.
REQ-019 SHALL compute UMUL/SMUL by iterative shift-add, one partial product per cycle, done in cycle N+WIDTH+2.
REQ-020 ADD: result_lo = op1+op2 mod 2^WIDTH, carry = bit WIDTH of sum.
REQ-021 SUB: result_lo = op1-op2 mod 2^WIDTH, carry = 1 when op1<op2 unsigned (borrow).
REQ-022 UMUL: {result_hi,result_lo} = full 2*WIDTH unsigned product.
REQ-023 SMUL: {result_hi,result_lo} = full 2*WIDTH two's-complement product, including most-negative x most-negative.
REQ-024 CMP: result_lo=0; gt = op1>op2 unsigned, eq = op1==op2.
REQ-025 NOP: result and flags all zero.
REQ-026 Flags not defined for an op SHALL be 0.
REQ-027 result_lo, result_hi, flags SHALL hold their values from done until the next done.
REQ-028 start asserted in the DONE cycle SHALL be ignored; acceptance resumes in IDLE.

Reset
REQ-029 rst_n low SHALL force IDLE, busy=0, done=0, result_lo=0, result_hi=0, flags=0 immediately, any cycle.
REQ-030 Reset mid-operation SHALL abort it with no done pulse; first start after release accepted normally.

Configuration
REQ-031 Macro SEQ_ALU_SMUL_EN defined: SMUL per REQ-023.
REQ-032 Macro undefined: no signed-multiply logic; opcode 100 completes in EXEC timing with results 0, err=1.
REQ-033 err SHALL be 0 for all other opcodes in both builds.

Structure
REQ-034 Opcode encodings, FSM state encodings, and flag bit indices SHALL reside in shared package alu_pkg.
REQ-035 Iterative multiplier SHALL be sub-module seq_mul (start/done, WIDTH-parameterised, signed-mode input).

Verification (WIDTH=12)
REQ-036 ADD op1=0x040, op2=0x001 -> done at N+2, result_lo=0x041, flags=0000.
REQ-037 UMUL 0xFFF x 0xFFF -> done at N+14, result_hi=0xFFE, result_lo=0x001; busy high N+1..N+13.
REQ-038 SMUL 0x800 x 0x800 -> result_hi=0x400, result_lo=0x000; without SEQ_ALU_SMUL_EN -> results 0, err=1 at N+2.
REQ-039 SUB 0x001-0x003 -> result_lo=0xFFE, carry=1; CMP 0x003 vs 0x001 -> gt=1, eq=0.
REQ-040 UMUL started, start pulsed with ADD at N+5 -> ignored; UMUL result delivered at N+14 unchanged.
REQ-041 rst_n low at N+6 during UMUL -> all outputs 0 at once, no done; later ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state encodings and flag bit indices shared by seq_alu and its bench.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_UMUL = 3'b011,
        OP_SMUL = 3'b100,
        OP_CMP  = 3'b101,
        OP_AND  = 3'b110,
        OP_OR   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // flags = {err, gt, eq, carry}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_EQ    = 1;
    localparam int FLAG_GT    = 2;
    localparam int FLAG_ERR   = 3;

endpackage

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiplier, one partial product per cycle, optional two's-complement mode.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : load a/b/sgn and begin (ignored bookkeeping is the caller's job)
//   sgn            : 1 = signed operands, 0 = unsigned
//   a, b           : WIDTH-bit multiplicand / multiplier
//   done           : high while the finished product is presented, for one cycle
//   product        : 2*WIDTH-bit product
module seq_mul #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic               run;
    logic               sgn_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier;

    // In signed mode the multiplier's MSB carries weight -2^(WIDTH-1),
    // so the last partial product is subtracted instead of added.
    assign addend  = !mplier[0] ? '0 : (sgn_q && cnt == CW'(1)) ? -mcand : mcand;
    assign done    = run && cnt == '0;
    assign product = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            sgn_q  <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            sgn_q  <= sgn;
            cnt    <= CW'(WIDTH);
            mcand  <= {{WIDTH{sgn & a[WIDTH-1]}}, a};
            acc    <= '0;
            mplier <= b;
        end else if (run) begin
            if (cnt != '0) begin
                acc    <= acc + addend;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                run    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU (NOP/ADD/SUB/UMUL/SMUL/CMP/AND/OR) with start/busy/done handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, opcode       : request and operation, sampled only in IDLE
//   op1, op2            : WIDTH-bit operands, sampled with start
//   busy                : high while an accepted operation is executing
//   done                : one-cycle pulse, results valid and held until the next done
//   result_lo/result_hi : result halves (result_hi nonzero only for products)
//   flags               : {err, gt, eq, carry}
// Macro SEQ_ALU_SMUL_EN enables signed multiply; without it opcode 100 returns zeros with err=1.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    state_e               state, nxt;
    logic [OPW-1:0]       op_q;
    logic [WIDTH-1:0]     a_q, b_q, lo, hi;
    logic [3:0]           fl;
    logic [WIDTH:0]       sum, diff;
    logic [2*WIDTH-1:0]   prod;
    logic [2:0]           op_in, op;
    logic                 accept, mul_in, mul_sgn, mul_done, capture;

    assign op_in = 3'(opcode);
    assign op    = 3'(op_q);

`ifdef SEQ_ALU_SMUL_EN
    assign mul_sgn = op_in == OP_SMUL;
`else
    assign mul_sgn = 1'b0;
`endif

    assign mul_in  = op_in == OP_UMUL || mul_sgn;
    assign accept  = state == S_IDLE && start;
    assign busy    = state == S_EXEC || state == S_MUL;
    assign done    = state == S_DONE;
    assign capture = state == S_EXEC || (state == S_MUL && mul_done);

    // The multiplier latches the raw inputs on the accepting edge itself,
    // so its first partial product is formed in the cycle after acceptance.
    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && mul_in),
        .sgn     (mul_sgn),
        .a       (op1),
        .b       (op2),
        .done    (mul_done),
        .product (prod)
    );

    // Borrow falls out as the extra MSB of the zero-extended difference.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        lo = '0;
        hi = '0;
        fl = '0;
        case (op)
            OP_ADD: begin
                lo             = sum[WIDTH-1:0];
                fl[FLAG_CARRY] = sum[WIDTH];
            end
            OP_SUB: begin
                lo             = diff[WIDTH-1:0];
                fl[FLAG_CARRY] = diff[WIDTH];
            end
            OP_UMUL: {hi, lo} = prod;
`ifdef SEQ_ALU_SMUL_EN
            OP_SMUL: {hi, lo} = prod;
`else
            OP_SMUL: fl[FLAG_ERR] = 1'b1;
`endif
            OP_CMP: begin
                fl[FLAG_GT] = a_q > b_q;
                fl[FLAG_EQ] = a_q == b_q;
            end
            OP_AND: lo = a_q & b_q;
            OP_OR:  lo = a_q | b_q;
            default: ;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = !start ? S_IDLE : mul_in ? S_MUL : S_EXEC;
            S_EXEC:  nxt = S_DONE;
            S_MUL:   nxt = mul_done ? S_DONE : S_MUL;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_lo <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_q <= opcode;
                a_q  <= op1;
                b_q  <= op2;
            end
            if (capture) begin
                result_lo <= lo;
                result_hi <= hi;
                flags     <= fl;
            end
        end
    end

endmodule
